// File: rtl/dmem_arb_multi_port_pkg.sv
// Shared defaults and helpers for the multi-port data memory and its write arbiter.
package dmem_arb_multi_port_pkg;

  localparam int DEF_NUM_PORTS = 10;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DEPTH     = 4096;
  localparam int MAX_PORTS     = 16;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Addresses are widened to 32 bits so the compare also works when DEPTH == 2**ADDR_W.
  function automatic logic addr_out_of_range(input logic [31:0] a, input int unsigned depth);
    return a >= depth;
  endfunction

endpackage

// File: rtl/dmem_arb_multi_port_rr_arbiter.sv
// Round-robin write arbiter: grants the first requester at or after rr_ptr, wrapping to 0.
module rr_arbiter
  import dmem_arb_multi_port_pkg::*;
#(
  parameter int N     = DEF_NUM_PORTS,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [N-1:0]     req_vec,
  input  logic             en,
  output logic [N-1:0]     grant_onehot,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any_grant
);

  logic [PTR_W-1:0] rr_ptr;

  always_comb begin
    int idx;
    grant_onehot = '0;
    grant_idx    = '0;
    any_grant    = 1'b0;
    idx          = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (en && !any_grant && req_vec[idx]) begin
        any_grant         = 1'b1;
        grant_idx         = PTR_W'(idx);
        grant_onehot[idx] = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner; with no candidates it stays put.
  always_ff @(posedge clk) begin
    if (RESET) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arb_multi_port.sv
// Shared N-port data memory: parallel registered reads, round-robin serialised writes, tb override port.
module dmem_arb_multi_port
  import dmem_arb_multi_port_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        RESET,
  input  logic                        tb_mode,
  input  logic                        tb_we,
  input  logic [ADDR_W-1:0]           tb_addr,
  input  logic [DATA_W-1:0]           tb_wdata,
  output logic [DATA_W-1:0]           tb_rdata,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS*DATA_W-1:0] rdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [NUM_PORTS-1:0]        addr_err,
  output logic [CNT_W-1:0]            conflict_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [NUM_PORTS-1:0] wr_cand;
  logic [NUM_PORTS-1:0] grant_onehot;
  logic [NUM_PORTS-1:0] port_oor;
  logic [NUM_PORTS-1:0] port_done;
  logic [PTR_W-1:0]     grant_idx;
  logic                 any_grant;
  logic [ADDR_W-1:0]    grant_addr;
  logic [DATA_W-1:0]    grant_wdata;
  logic                 tb_oor;
  logic                 multi_cand;

  assign wr_cand     = req & we;
  assign port_done   = (req & ~we) | grant_onehot;
  assign grant_addr  = addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign grant_wdata = wdata[int'(grant_idx)*DATA_W +: DATA_W];
  assign tb_oor      = addr_out_of_range(32'(tb_addr), DEPTH);
  assign multi_cand  = $countones(wr_cand) > 1;

  always_comb begin
    port_oor = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_oor[i] = addr_out_of_range(32'(addr[i*ADDR_W +: ADDR_W]), DEPTH);
    end
  end

  rr_arbiter #(.N(NUM_PORTS), .PTR_W(PTR_W)) u_arb (
    .clk          (clk),
    .RESET        (RESET),
    .req_vec      (wr_cand),
    .en           (~tb_mode),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any_grant    (any_grant)
  );

  // Single write port; contents deliberately survive RESET so a tb preload is kept.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      if (tb_mode) begin
        if (tb_we && !tb_oor) mem[tb_addr[IDX_W-1:0]] <= tb_wdata;
      end else if (any_grant && !port_oor[grant_idx]) begin
        mem[grant_addr[IDX_W-1:0]] <= grant_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      rdata    <= '0;
      ack      <= '0;
      addr_err <= '0;
    end else if (tb_mode) begin
      ack      <= '0;
      addr_err <= '0;
    end else begin
      ack      <= port_done;
      addr_err <= port_done & port_oor;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (req[i] && !we[i]) begin
          rdata[i*DATA_W +: DATA_W] <= port_oor[i] ? '0 : mem[addr[i*ADDR_W +: IDX_W]];
        end
      end
    end
  end

  // tb read data only refreshes while the tb port owns the memory.
  always_ff @(posedge clk) begin
    if (RESET) begin
      tb_rdata <= '0;
    end else if (tb_mode) begin
      tb_rdata <= tb_oor ? '0 : mem[tb_addr[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      conflict_cnt <= '0;
    end else if (!tb_mode && multi_cand && conflict_cnt != CNT_MAX) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule
